// File: rtl/dsp_sys_arr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_sys_arr_pkg
//  Description : Shared types and constants for the DSP systolic array and
//                its result-drain stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package dsp_sys_arr_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } single_float;

    typedef struct packed {
        single_float data;
        logic        dirty;
    } float_reg;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } error;

    typedef struct packed {
        single_float data;
    } drain_entry_t;

    localparam int DRAIN_DEPTH = 4;

    function automatic word_t float_to_word(input single_float f);
        return word_t'(f);
    endfunction

endpackage
`default_nettype wire

// File: rtl/drain_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : drain_fifo
//  Description : Single-column synchronous FIFO holding drained PE results.
//  Revision    : 1.0 - initial release
// ============================================================================
module drain_fifo
    import dsp_sys_arr_pkg::*;
#(
    parameter int DEPTH = DRAIN_DEPTH
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  drain_entry_t             wdata_i,
    output drain_entry_t             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL    = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE = (c_AW+1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

    drain_entry_t    mem_q [DEPTH];
    logic [c_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_AW:0]   count_q, count_d;
    logic            w_push_ok;
    logic            w_pop_ok;

    assign full_o  = (count_q == c_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = push_i && (!full_o || pop_i);
    assign w_pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push_ok) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
        if (w_pop_ok) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end
        case ({w_push_ok, w_pop_ok})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sys_arr_drain.sv
`default_nettype none
// ============================================================================
//  Module      : sys_arr_drain
//  Description : Buffers systolic-array column results and serialises them
//                round-robin onto one valid/ready stream with sticky status.
//  Revision    : 1.0 - initial release
// ============================================================================
module sys_arr_drain
    import dsp_sys_arr_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = DRAIN_DEPTH
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  float_reg [N-1:0]       col_in,
    input  error     [N-1:0]       col_err,
    output logic                   stall,
    output word_t                  out_data,
    output logic [$clog2(N)-1:0]   out_col,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   clr_err,
    output logic                   err_ovf,
    output logic                   err_unf,
    output logic                   err_drop
);

    localparam int c_CW   = $clog2(N);
    localparam int c_CNTW = $clog2(DEPTH) + 1;
    localparam logic [c_CNTW-1:0] c_STALL_LVL = c_CNTW'(DEPTH - 1);
    localparam logic [c_CW-1:0]   c_LAST_COL  = c_CW'(N - 1);
    localparam logic [c_CW-1:0]   c_COL_ONE   = c_CW'(1);

    drain_entry_t      w_rdata [N];
    logic [c_CNTW-1:0] w_count [N];
    logic [N-1:0]      w_full;
    logic [N-1:0]      w_empty;
    logic [N-1:0]      w_push;
    logic [N-1:0]      w_pop;

    logic              w_load;
    logic              w_found;
    logic [c_CW-1:0]   w_gnt;
    logic              w_stall;
    logic              w_ovf_set, w_unf_set, w_drop_set;

    logic              out_valid_q, out_valid_d;
    word_t             out_data_q,  out_data_d;
    logic [c_CW-1:0]   out_col_q,   out_col_d;
    logic [c_CW-1:0]   rr_q,        rr_d;
    logic              err_ovf_q,   err_ovf_d;
    logic              err_unf_q,   err_unf_d;
    logic              err_drop_q,  err_drop_d;

    generate
        for (genvar i = 0; i < N; i++) begin : g_col
            drain_entry_t w_wdata;
            assign w_wdata.data = col_in[i].data;
            assign w_push[i]    = col_in[i].dirty;

            drain_fifo #(
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk     (clk),
                .n_rst   (n_rst),
                .push_i  (w_push[i]),
                .pop_i   (w_pop[i]),
                .wdata_i (w_wdata),
                .rdata_o (w_rdata[i]),
                .count_o (w_count[i]),
                .full_o  (w_full[i]),
                .empty_o (w_empty[i])
            );
        end
    endgenerate

    assign w_load = !out_valid_q || out_ready;

    // Cyclic search for the first non-empty column starting at rr.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_gnt   = '0;
        w_pop   = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!w_found && !w_empty[idx]) begin
                w_found = 1'b1;
                w_gnt   = c_CW'(idx);
            end
        end
        if (w_load && w_found) begin
            w_pop[w_gnt] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_col_d   = out_col_q;
        rr_d        = rr_q;
        if (w_load) begin
            if (w_found) begin
                out_valid_d = 1'b1;
                out_data_d  = float_to_word(w_rdata[w_gnt].data);
                out_col_d   = w_gnt;
                rr_d        = (w_gnt == c_LAST_COL) ? '0 : w_gnt + c_COL_ONE;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        w_stall    = 1'b0;
        w_ovf_set  = 1'b0;
        w_unf_set  = 1'b0;
        w_drop_set = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_count[i] >= c_STALL_LVL) begin
                w_stall = 1'b1;
            end
            if (col_in[i].dirty) begin
                w_ovf_set = w_ovf_set | col_err[i].overflow;
                w_unf_set = w_unf_set | col_err[i].underflow;
                if (w_full[i] && !w_pop[i]) begin
                    w_drop_set = 1'b1;
                end
            end
        end
        err_ovf_d  = clr_err ? 1'b0 : (err_ovf_q  | w_ovf_set);
        err_unf_d  = clr_err ? 1'b0 : (err_unf_q  | w_unf_set);
        err_drop_d = clr_err ? 1'b0 : (err_drop_q | w_drop_set);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_col_q   <= '0;
            rr_q        <= '0;
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
            err_drop_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_col_q   <= out_col_d;
            rr_q        <= rr_d;
            err_ovf_q   <= err_ovf_d;
            err_unf_q   <= err_unf_d;
            err_drop_q  <= err_drop_d;
        end
    end

    assign stall     = w_stall;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_col   = out_col_q;
    assign err_ovf   = err_ovf_q;
    assign err_unf   = err_unf_q;
    assign err_drop  = err_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_sys_arr_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sys_arr_drain
//  Description : Directed scoreboard bench for the systolic-array drain stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_arr_drain;
    import dsp_sys_arr_pkg::*;

    typedef struct {
        logic [1:0]  col;
        logic [31:0] data;
    } exp_t;

    logic             clk;
    logic             n_rst;
    float_reg [3:0]   col_in;
    error     [3:0]   col_err;
    logic             stall;
    word_t            out_data;
    logic [1:0]       out_col;
    logic             out_valid;
    logic             out_ready;
    logic             clr_err;
    logic             err_ovf, err_unf, err_drop;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    sys_arr_drain #(.N(4), .DEPTH(4)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .col_in    (col_in),
        .col_err   (col_err),
        .stall     (stall),
        .out_data  (out_data),
        .out_col   (out_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .clr_err   (clr_err),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf),
        .err_drop  (err_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every accepted word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (n_rst && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_mis++;
                $display("FAIL unexpected_word: got col %0d data %h, required no word", out_col, out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_col !== e.col || out_data !== e.data) begin
                    n_mis++;
                    $display("FAIL out_word: got col %0d data %h, required col %0d data %h",
                             out_col, out_data, e.col, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [1:0] c, input logic [31:0] d);
        exp_t e;
        e.col  = c;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic clear_inputs();
        col_in  = '0;
        col_err = '0;
        clr_err = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < max_cycles) begin
            tick();
            i++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain_timeout: got %0d words outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        #2 n_rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        n_rst = 1'b1;
        tick();
    endtask

    logic [31:0] rr_vals [4];
    logic [31:0] bp_vals [5];

    initial begin
        rr_vals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        bp_vals = '{32'h00000001, 32'h40000000, 32'h40400000, 32'h40800000, 32'hC0A00000};
        clear_inputs();
        out_ready = 1'b1;
        n_rst     = 1'b1;
        #1 n_rst  = 1'b0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data",  out_data,       32'd0);
        chk("reset_out_col",   32'(out_col),   32'd0);
        chk("reset_stall",     32'(stall),     32'd0);
        chk("reset_errs",      {29'd0, err_ovf, err_unf, err_drop}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();

        // Single entry: two-cycle latency, then the output empties again.
        col_in[2] = {32'h3F800000, 1'b1};
        expect_word(2'd2, 32'h3F800000);
        tick();
        clear_inputs();
        chk("latency_t1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("latency_t2_valid", 32'(out_valid), 32'd1);
        chk("latency_t2_col",   32'(out_col),   32'd2);
        tick();
        chk("single_after_valid", 32'(out_valid), 32'd0);
        wait_drain(10);

        // Round-robin from a fresh pointer, twice.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                col_in[c] = {rr_vals[c], 1'b1};
                expect_word(2'(c), rr_vals[c]);
            end
            tick();
            clear_inputs();
            wait_drain(12);
        end

        // Output hold: NaN filler from column 3 parked in the output register.
        out_ready = 1'b0;
        col_in[3] = {32'h7FC00001, 1'b1};
        expect_word(2'd3, 32'h7FC00001);
        tick();
        clear_inputs();
        tick();
        for (int h = 0; h < 5; h++) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data",  out_data,       32'h7FC00001);
            chk("hold_col",   32'(out_col),   32'd3);
            tick();
        end

        // Backpressure on column 0 while the output is blocked.
        for (int p = 0; p < 5; p++) begin
            col_in[0] = {bp_vals[p], 1'b1};
            if (p < 4) expect_word(2'd0, bp_vals[p]);
            tick();
            clear_inputs();
            chk("bp_stall",    32'(stall),    (p >= 2) ? 32'd1 : 32'd0);
            chk("bp_err_drop", 32'(err_drop), (p == 4) ? 32'd1 : 32'd0);
        end
        out_ready = 1'b1;
        wait_drain(20);
        chk("bp_stall_released", 32'(stall),    32'd0);
        chk("bp_drop_sticky",    32'(err_drop), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_drop", 32'(err_drop), 32'd0);

        // Error flags: qualification by dirty, set, and clear priority.
        col_err[0].overflow = 1'b1;
        tick();
        clear_inputs();
        chk("err_ovf_not_dirty", 32'(err_ovf), 32'd0);
        col_in[1]           = {32'h3F800000, 1'b1};
        col_err[1].overflow = 1'b1;
        expect_word(2'd1, 32'h3F800000);
        tick();
        clear_inputs();
        chk("err_ovf_set", 32'(err_ovf), 32'd1);
        chk("err_unf_idle", 32'(err_unf), 32'd0);
        col_in[2]            = {32'h40000000, 1'b1};
        col_err[2].underflow = 1'b1;
        clr_err              = 1'b1;
        expect_word(2'd2, 32'h40000000);
        tick();
        clear_inputs();
        chk("err_unf_clr_prio", 32'(err_unf), 32'd0);
        chk("err_ovf_cleared",  32'(err_ovf), 32'd0);
        wait_drain(10);

        // Reset mid-drain with six entries buffered.
        out_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            col_in[0] = {rr_vals[p], 1'b1};
            if (p == 1) col_err[0].overflow = 1'b1;
            tick();
            clear_inputs();
        end
        for (int c = 0; c < 4; c++) col_in[c] = {rr_vals[c], 1'b1};
        tick();
        clear_inputs();
        chk("pre_reset_stall", 32'(stall),   32'd1);
        chk("pre_reset_ovf",   32'(err_ovf), 32'd1);
        #2 n_rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_stall", 32'(stall),     32'd0);
        chk("midrst_data",  out_data,       32'd0);
        chk("midrst_errs",  {29'd0, err_ovf, err_unf, err_drop}, 32'd0);
        exp_q.delete();
        out_ready = 1'b1;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (8) tick();
        chk("post_reset_no_word", 32'(out_valid), 32'd0);
        wait_drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sys_arr_drain.md
# sys_arr_drain

Result-drain stage at the bottom edge of the DSP systolic array. It accepts `float_reg` results emitted by the N column PEs, marked valid by their `dirty` bit, and buffers each column in a small FIFO. It asserts backpressure to the array before any buffer can overflow, then serialises the results onto a single valid/ready word stream in round-robin column order. It also accumulates sticky overflow/underflow status from the PE `error` outputs.

## Interface
Parameters:
- `N`, 4: number of array columns (≥2).
- `DEPTH`, 4: entries per column FIFO (power of two, ≥2).

Ports:
- `clk`  in  1  single clock, rising edge.
- `n_rst`  in  1  reset, asynchronous and active-low.
- `col_in`  in  N×`float_reg`  column results; an entry is valid when `.dirty` = 1.
- `col_err`  in  N×`error`  per-column error flags, qualified by the same column's `.dirty`.
- `stall`  out  1  backpressure to the array.
- `out_data`  out  `word_t`  raw FP32 bits of the result (sign/exp/mantissa).
- `out_col`  out  $clog2(N)  source column of `out_data`.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  consumer accepts the word.
- `clr_err`  in  1  one-cycle pulse that clears the sticky flags.
- `err_ovf`, `err_unf`  out  1 each  sticky FP overflow and underflow.
- `err_drop`  out  1  sticky flag: a result was lost to a full FIFO.

## Operation
- **Capture.** For each column i, a push occurs when `col_in[i].dirty` = 1. The push is accepted if `count[i] < DEPTH`, or if `count[i] == DEPTH` and column i pops in the same cycle. Otherwise the entry is discarded and `err_drop` is set.
- **Stored fields.** Only `.data` is stored; `.dirty` is not.
- **Stall.** `stall` is combinational: it is 1 when any `count[i] >= DEPTH-1`. The array must not present new dirty entries in the cycle after it samples `stall` = 1. This leaves one slot of margin for an in-flight result.
- **Arbitration.**
  - A single output register (`out_valid`/`out_data`/`out_col`) loads when it is empty or when `out_valid && out_ready`.
  - The load source is the first non-empty column at or after pointer `rr`, searching cyclically.
  - That column pops, and `rr` becomes (granted + 1) mod N.
  - If no column is non-empty, `out_valid` is cleared, or stays cleared.
- **Simultaneous push and pop** on the same column: both take effect and the count is unchanged.
- **Errors.** On an accepted or dropped dirty entry, `err_ovf |= col_err[i].overflow` and `err_unf |= col_err[i].underflow`.
  - `clr_err` takes priority over a set in the same cycle; the flags read 0 the next cycle.
- **Data integrity.** Data is not modified; NaN and denormal values pass through untouched.

## Timing
- **Reset values.** `out_valid` = 0, `out_data` = 0, `out_col` = 0, `stall` = 0, all three error flags = 0, all counts and pointers = 0, `rr` = 0.
- **Latency.** A dirty entry at cycle t is written at the end of t. With the output empty, `out_valid` = 1 in cycle t+1 (registered at the edge ending t+1) and is visible from t+2. That is, 2 cycles from input to output.
- **Throughput.** One word per cycle while `out_ready` = 1 and data is buffered.
- **Hold under backpressure.** When `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_col` stay stable.
- **Reset mid-operation.** All buffered data is discarded immediately (asynchronously). `stall` drops to 0 asynchronously.
- **Pointer wrap.** FIFO pointers are $clog2(DEPTH) bits wide and wrap naturally. Counts are $clog2(DEPTH)+1 bits wide.

## Structure
- Add `drain_entry_t` (packed: `single_float data`) to `dsp_sys_arr_pkg`. Export a `DRAIN_DEPTH` default constant from the same package.
- Reuse the existing `float_reg`, `error` and `word_t` definitions from that package.
- One sub-module: `drain_fifo`, a single-column synchronous FIFO with push, pop, `count`, `full` and `empty`. It is instantiated N times.
- The arbiter and output register stay in the top module.

## Test plan
- **Single entry.** Reset, then one `col_in[2]` = {3F800000, dirty}, with `out_ready` = 1. Required: `out_valid` 2 cycles later with `out_data` = 3F800000 and `out_col` = 2, then `out_valid` = 0.
- **Round-robin order.** All 4 columns dirty in the same cycle with values 1.0, 2.0, 3.0, 4.0 (3F800000, 40000000, 40400000, 40800000). Required: output order is columns 0,1,2,3 on consecutive cycles. A repeat of the same pattern outputs 0,1,2,3 again.
- **Backpressure.** Hold `out_ready` = 0 and push 3 entries into column 0. Required: `stall` = 1 after the 3rd push. A 4th push is accepted with `err_drop` = 0. A 5th push sets `err_drop` = 1. Releasing `out_ready` then drains exactly 4 words in FIFO order.
- **Output hold.** Hold `out_ready` = 0 for 5 cycles while `out_valid` = 1. Required: `out_data` and `out_col` are unchanged. When `out_ready` goes to 1, the word is accepted in that cycle.
- **Errors.** A dirty entry with `col_err[1].overflow` = 1 sets `err_ovf`. Then `clr_err` pulsed in the same cycle as a dirty entry with underflow = 1 leaves `err_unf` = 0.
- **Reset mid-drain.** Assert `n_rst` = 0 with 6 entries buffered. Required: `out_valid`, `stall` and all flags go to 0 immediately, and no stale word appears after reset is released.
